// File: rtl/p405s_itlb_pkg.sv
// Shared types and constants for the ISTLB shadow controller: FSM state
// encoding, default entry count and miss-counter width.
package p405s_itlb_pkg;

  localparam int NUM_ENTRIES_DEF = 4;
  localparam int MISS_CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMP   = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FILL  = 3'd4,
    ST_RETRY = 3'd5,
    ST_DRAIN = 3'd6
  } state_e;

endpackage

// File: rtl/p405s_itlb_victim_ptr.sv
// Round-robin victim pointer for the shadow TLB. It steps once per committed
// fill and presents the victim as a one-hot write strobe.
module p405s_itlb_victim_ptr
  import p405s_itlb_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int VIC_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   advance,
  output logic [NUM_ENTRIES-1:0] onehot
);

  logic [VIC_W-1:0] ptr;

  // NUM_ENTRIES is a power of two, so the natural wrap is the modulo.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr + VIC_W'(1);
    end
  end

  assign onehot = NUM_ENTRIES'(1) << ptr;

endmodule

// File: rtl/p405s_itlb_shadow_ctl.sv
// ISTLB shadow sequencer: qualifies compare hits, runs UTLB lookups on a miss
// and refills a round-robin victim. Optional miss counter: P405S_ITLB_SHADOW_PERF_EN.
module p405s_itlb_shadow_ctl
  import p405s_itlb_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int VIC_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   CB,
  input  logic                   Reset_NEG,
  input  logic                   isReq,
  input  logic                   msrIrL2,
  input  logic [NUM_ENTRIES-1:0] entryHit,
  input  logic                   isFlush,
  input  logic                   utlbAck,
  input  logic                   utlbHit,
  output logic                   CompE2,
  output logic [NUM_ENTRIES-1:0] writeShadow,
  output logic                   isAbort_NEG,
  output logic [NUM_ENTRIES-1:0] entryValid,
  output logic                   utlbReq,
  output logic                   isStall,
  output logic                   isMissExc,
`ifdef P405S_ITLB_SHADOW_PERF_EN
  output logic [MISS_CNT_W-1:0]  missCnt,
`endif
  output logic [2:0]             dbg_state
);

  state_e                 state;
  state_e                 state_nxt;
  logic                   hit;
  logic                   fill_en;
  logic [NUM_ENTRIES-1:0] victim_oh;
  logic [NUM_ENTRIES-1:0] entry_valid_q;

  assign hit     = |(entryHit & entry_valid_q);
  assign fill_en = (state == ST_FILL) && !isFlush;

  p405s_itlb_victim_ptr #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .VIC_W       (VIC_W)
  ) u_victim_ptr (
    .clk     (CB),
    .rst_n   (Reset_NEG),
    .advance (fill_en),
    .onehot  (victim_oh)
  );

  always_ff @(posedge CB) begin
    if (!Reset_NEG) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // UTLB handshake: utlbReq rises in REQ and stays high through WAIT until the
  // single-cycle utlbAck; utlbHit is only meaningful in the utlbAck cycle.
  // A flushed lookup still owns the UTLB, so DRAIN waits out its utlbAck.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (isReq) state_nxt = ST_CMP;
      end
      ST_CMP: begin
        if (hit || !msrIrL2) begin
          state_nxt = isReq ? ST_CMP : ST_IDLE;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (isFlush) begin
          state_nxt = utlbAck ? ST_IDLE : ST_DRAIN;
        end else if (utlbAck) begin
          state_nxt = utlbHit ? ST_FILL : ST_IDLE;
        end
      end
      ST_FILL:  state_nxt = isFlush ? ST_IDLE : ST_RETRY;
      ST_RETRY: state_nxt = ST_CMP;
      ST_DRAIN: begin
        if (utlbAck) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are held at their idle levels while reset is asserted.
  always_comb begin
    CompE2      = 1'b0;
    writeShadow = '0;
    isAbort_NEG = 1'b1;
    utlbReq     = 1'b0;
    isStall     = 1'b0;
    isMissExc   = 1'b0;
    if (Reset_NEG) begin
      case (state)
        ST_IDLE: CompE2 = isReq;
        ST_CMP: begin
          if (hit || !msrIrL2) begin
            CompE2 = isReq;
          end else begin
            isStall     = 1'b1;
            isAbort_NEG = 1'b0;
          end
        end
        ST_REQ: begin
          utlbReq = 1'b1;
          isStall = 1'b1;
        end
        ST_WAIT: begin
          utlbReq   = 1'b1;
          isStall   = 1'b1;
          isMissExc = utlbAck && !utlbHit && !isFlush;
        end
        ST_FILL: begin
          isStall     = 1'b1;
          writeShadow = fill_en ? victim_oh : '0;
        end
        ST_RETRY: begin
          CompE2  = 1'b1;
          isStall = 1'b1;
        end
        ST_DRAIN: isStall = 1'b1;
        default: ;
      endcase
    end
  end

  // Flush beats a same-cycle fill so the entry stays invalid.
  always_ff @(posedge CB) begin
    if (!Reset_NEG) begin
      entry_valid_q <= '0;
    end else if (isFlush) begin
      entry_valid_q <= '0;
    end else if (fill_en) begin
      entry_valid_q <= entry_valid_q | victim_oh;
    end
  end

  assign entryValid = entry_valid_q;
  assign dbg_state  = state;

`ifdef P405S_ITLB_SHADOW_PERF_EN
  logic [MISS_CNT_W-1:0] miss_cnt_q;

  always_ff @(posedge CB) begin
    if (!Reset_NEG) begin
      miss_cnt_q <= '0;
    end else if (state == ST_CMP && state_nxt == ST_REQ && miss_cnt_q != '1) begin
      miss_cnt_q <= miss_cnt_q + MISS_CNT_W'(1);
    end
  end

  assign missCnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_p405s_itlb_shadow_ctl.sv
// Self-checking bench for p405s_itlb_shadow_ctl; write strobes are checked
// against a scoreboard queue fed by a victim-pointer model.
module tb_p405s_itlb_shadow_ctl;
  import p405s_itlb_pkg::*;

  localparam int N = 4;

  logic         CB = 1'b0;
  logic         Reset_NEG;
  logic         isReq;
  logic         msrIrL2;
  logic [N-1:0] entryHit;
  logic         isFlush;
  logic         utlbAck;
  logic         utlbHit;
  logic         CompE2;
  logic [N-1:0] writeShadow;
  logic         isAbort_NEG;
  logic [N-1:0] entryValid;
  logic         utlbReq;
  logic         isStall;
  logic         isMissExc;
  logic [2:0]   dbg_state;
`ifdef P405S_ITLB_SHADOW_PERF_EN
  logic [15:0]  missCnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] model_valid;
  logic [1:0]   model_ptr;
  int           stall_cycles;
  int           miss_exc_seen;

  p405s_itlb_shadow_ctl #(.NUM_ENTRIES(N)) dut (
    .CB          (CB),
    .Reset_NEG   (Reset_NEG),
    .isReq       (isReq),
    .msrIrL2     (msrIrL2),
    .entryHit    (entryHit),
    .isFlush     (isFlush),
    .utlbAck     (utlbAck),
    .utlbHit     (utlbHit),
    .CompE2      (CompE2),
    .writeShadow (writeShadow),
    .isAbort_NEG (isAbort_NEG),
    .entryValid  (entryValid),
    .utlbReq     (utlbReq),
    .isStall     (isStall),
    .isMissExc   (isMissExc),
`ifdef P405S_ITLB_SHADOW_PERF_EN
    .missCnt     (missCnt),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 CB = ~CB;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CB);
    #1;
  endtask

  task automatic reset_dut();
    Reset_NEG = 1'b0;
    isReq = 1'b0; msrIrL2 = 1'b1; entryHit = '0;
    isFlush = 1'b0; utlbAck = 1'b0; utlbHit = 1'b0;
    repeat (2) step();
    Reset_NEG = 1'b1;
    model_valid = '0;
    model_ptr   = '0;
  endtask

  // scoreboard monitor: sampled on the falling edge
  always @(negedge CB) begin
    if (isStall) stall_cycles++;
    if (isMissExc) miss_exc_seen++;
    if (writeShadow != '0) begin
      if (exp_q.size() == 0) check("ws_unexpected", writeShadow, 0);
      else check("ws_seq", writeShadow, exp_q.pop_front());
    end
  end

  // IDLE -> CMP -> REQ -> WAIT, leaving the bench in the first WAIT cycle.
  task automatic to_wait(input logic [N-1:0] cmp_hits);
    isReq = 1'b1; entryHit = '0;
    step();
    isReq = 1'b0; entryHit = cmp_hits;
    step();
    entryHit = '0;
    step();
  endtask

  // Full miss from IDLE with the UTLB answering after n_wait WAIT cycles.
  task automatic miss_seq(input int n_wait, input logic uhit, input logic [N-1:0] cmp_hits);
    logic [N-1:0] oh;
    int exc_before;
    stall_cycles = 0;
    exc_before = miss_exc_seen;
    isReq = 1'b1; entryHit = '0;
    #1 check("idle_compe2", CompE2, 1);
    step();
    isReq = 1'b0; entryHit = cmp_hits;
    #1 check("cmp_stall", isStall, 1);
    check("cmp_abort_n", isAbort_NEG, 0);
    step();
    entryHit = '0;
    #1 check("req_utlbreq", utlbReq, 1);
    step();
    for (int i = 1; i < n_wait; i++) begin
      #1 check("wait_utlbreq", utlbReq, 1);
      step();
    end
    utlbAck = 1'b1; utlbHit = uhit;
    oh = N'(1) << model_ptr;
    if (uhit) begin
      exp_q.push_back(oh);
      model_valid = model_valid | oh;
      model_ptr = model_ptr + 2'd1;
    end
    #1 check("ack_missexc", isMissExc, !uhit);
    step();
    utlbAck = 1'b0; utlbHit = 1'b0;
    if (uhit) begin
      #1 check("fill_stall", isStall, 1);
      step();
      #1 check("retry_compe2", CompE2, 1);
      step();
      entryHit = oh;
      #1 check("retry_hit_nostall", isStall, 0);
      check("valid_after_fill", entryValid, model_valid);
      step();
      entryHit = '0;
      check("stall_len", stall_cycles, 4 + n_wait);
    end else begin
      check("missexc_pulses", miss_exc_seen - exc_before, 1);
      check("miss_valid_kept", entryValid, model_valid);
    end
    check("back_idle", dbg_state, ST_IDLE);
  endtask

  initial begin
    miss_exc_seen = 0;
    stall_cycles  = 0;
    reset_dut();

    // reset state
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_valid", entryValid, 0);
    check("rst_compe2", CompE2, 0);
    check("rst_ws", writeShadow, 0);
    check("rst_utlbreq", utlbReq, 0);
    check("rst_stall", isStall, 0);
    check("rst_missexc", isMissExc, 0);
    check("rst_abort_n", isAbort_NEG, 1);

    // real mode, back-to-back translations without stalling
    step();
    msrIrL2 = 1'b0; isReq = 1'b1;
    #1 check("real_compe2_a", CompE2, 1);
    step();
    #1 check("real_compe2_b", CompE2, 1);
    check("real_nostall", isStall, 0);
    step();
    isReq = 1'b0;
    #1 check("real_compe2_off", CompE2, 0);
    step();
    check("real_idle", dbg_state, ST_IDLE);
    msrIrL2 = 1'b1;

    // first miss: UTLB answers in the third WAIT cycle
    miss_seq(3, 1'b1, '0);

    // valid entry hit, back-to-back
    isReq = 1'b1;
    step();
    entryHit = 4'b0001;
    #1 check("hit_nostall", isStall, 0);
    check("hit_b2b_compe2", CompE2, 1);
    step();
    isReq = 1'b0;
    #1 check("hit2_nostall", isStall, 0);
    step();
    entryHit = '0;
    check("hit_idle", dbg_state, ST_IDLE);

    miss_seq(2, 1'b1, '0);

    // reset in WAIT, late UTLB ack must be ignored
    to_wait('0);
    Reset_NEG = 1'b0;
    step();
    Reset_NEG = 1'b1;
    model_valid = '0;
    model_ptr   = '0;
    utlbAck = 1'b1; utlbHit = 1'b1;
    #1 check("rstwait_state", dbg_state, ST_IDLE);
    check("rstwait_utlbreq", utlbReq, 0);
    step();
    utlbAck = 1'b0; utlbHit = 1'b0;
    step();
    check("rstwait_valid", entryValid, 0);
    check("rstwait_idle", dbg_state, ST_IDLE);

    // five misses: victim wraps 0001,0010,0100,1000,0001
    for (int k = 0; k < 5; k++) begin
      miss_seq($urandom_range(1, 4), 1'b1, '0);
    end
    check("wrap_valid", entryValid, 4'b1111);

    // several hit bits at once still count as a hit
    isReq = 1'b1;
    step();
    isReq = 1'b0; entryHit = 4'b1111;
    #1 check("multihit_nostall", isStall, 0);
    check("multihit_abort_n", isAbort_NEG, 1);
    step();
    entryHit = '0;

    // UTLB miss
    miss_seq(2, 1'b0, '0);

    // flush in WAIT: drain the outstanding ack, no fill
    to_wait('0);
    isFlush = 1'b1;
    step();
    isFlush = 1'b0;
    model_valid = '0;
    #1 check("flush_valid", entryValid, 0);
    check("flush_drain", dbg_state, ST_DRAIN);
    check("drain_utlbreq", utlbReq, 0);
    step();
    check("drain_hold", dbg_state, ST_DRAIN);
    utlbAck = 1'b1; utlbHit = 1'b1;
    step();
    utlbAck = 1'b0; utlbHit = 1'b0;
    check("drain_idle", dbg_state, ST_IDLE);

    // hits reported by invalid entries are not hits
    miss_seq(1, 1'b1, 4'b1111);

    // flush in FILL wins over the write
    to_wait('0);
    utlbAck = 1'b1; utlbHit = 1'b1;
    step();
    utlbAck = 1'b0; utlbHit = 1'b0;
    isFlush = 1'b1;
    #1 check("flushfill_ws", writeShadow, 0);
    step();
    isFlush = 1'b0;
    check("flushfill_valid", entryValid, 0);
    check("flushfill_idle", dbg_state, ST_IDLE);

`ifdef P405S_ITLB_SHADOW_PERF_EN
    reset_dut();
    for (int k = 0; k < 3; k++) miss_seq(1, 1'b1, '0);
    check("perf_cnt3", missCnt, 3);
    force dut.miss_cnt_q = 16'hFFFF;
    step();
    release dut.miss_cnt_q;
    miss_seq(1, 1'b1, '0);
    check("perf_sat", missCnt, 16'hFFFF);
`endif

    step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p405s_itlb_shadow_ctl.md
Name: p405s_itlb_shadow_ctl

Overview:
- Sequencer for the 4-entry instruction shadow TLB (ISTLB) compare array.
- Qualifies per-entry compare hits and, on a shadow miss, runs a request/acknowledge lookup into the unified TLB (UTLB).
- Writes the returned translation into a victim entry chosen round-robin.
- Drives the compare-register enable, the write-shadow strobe and the fetch-abort signal to each compare cell. Sits between the fetch unit and the compare cells.

Parameters:
- NUM_ENTRIES, 4, number of shadow entries; must be a power of 2, range 2..8.
- VIC_W, 2, victim pointer width; equals log2(NUM_ENTRIES).

Ports:
- CB  in  1  clock; all state changes on rising edge.
- Reset_NEG  in  1  synchronous active-low reset.
- isReq  in  1  fetch translation request; EA is valid in this cycle.
- msrIrL2  in  1  instruction relocation enable; 0 means real mode.
- entryHit  in  NUM_ENTRIES  per-entry Hit from the compare cells; valid one cycle after CompE2.
- isFlush  in  1  invalidate all shadow entries; context sync or TLB write.
- utlbAck  in  1  UTLB lookup complete; one-cycle pulse.
- utlbHit  in  1  qualifies utlbAck; 1 means translation found.
- CompE2  out  1  loads the EA compare registers in all cells.
- writeShadow  out  NUM_ENTRIES  one-hot write strobe to the victim entry.
- isAbort_NEG  out  1  0 aborts the in-flight fetch.
- entryValid  out  NUM_ENTRIES  per-entry Valid to the compare cells.
- utlbReq  out  1  UTLB lookup request; held until utlbAck.
- isStall  out  1  fetch stall.
- isMissExc  out  1  one-cycle ITLB-miss exception pulse.

Behaviour:
- Reset (Reset_NEG=0 at an edge), regardless of state:
  - state=IDLE; entryValid=0; victim pointer=0.
  - All strobes and requests deassert: CompE2=0, writeShadow=0, utlbReq=0, isStall=0, isMissExc=0, isAbort_NEG=1.
  - A UTLB acknowledge that arrives after reset is ignored.
- States:
  - IDLE: isReq=1 drives CompE2=1 combinationally in the same cycle, then go to CMP. Otherwise stay in IDLE.
  - CMP: hit = |(entryHit & entryValid).
    - hit=1 or msrIrL2=0: translation done. If isReq=1, reassert CompE2 and stay in CMP (back-to-back, one translation per cycle). Otherwise go to IDLE.
    - hit=0 and msrIrL2=1: isStall=1, isAbort_NEG=0 for this one cycle, go to REQ.
  - REQ: utlbReq=1, isStall=1, go to WAIT.
  - WAIT: utlbReq=1, isStall=1, until utlbAck.
    - utlbAck with utlbHit=1: go to FILL.
    - utlbAck with utlbHit=0: isMissExc=1 for one cycle, go to IDLE.
  - FILL: writeShadow = one-hot of the victim pointer; set entryValid[victim]; victim pointer increments mod NUM_ENTRIES (wraps 3 to 0). isStall=1. Go to RETRY.
  - RETRY: CompE2=1, isStall=1, go to CMP. The filled entry then hits.
- Miss latency: CMP to retry compare is 4 cycles plus the UTLB wait.
- Multiple entryHit bits set together still count as a hit; no error is raised.
- isFlush:
  - Clears entryValid on the next edge in any state.
  - In WAIT or FILL the flush also cancels the fill: the write is suppressed and the state returns to IDLE.
  - In WAIT the controller sits in DRAIN, holding utlbReq=0, until utlbAck arrives, then goes to IDLE.
- isFlush together with a FILL write: the flush wins and the entry stays invalid.
- isReq is ignored while isStall=1.

Optional Feature:
- Macro P405S_ITLB_SHADOW_PERF_EN.
- When defined, adds output missCnt (16 bits): counts CMP-to-REQ transitions, saturates at 0xFFFF, clears on reset.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package p405s_itlb_pkg: state encoding enum (IDLE, CMP, REQ, WAIT, FILL, RETRY, DRAIN), NUM_ENTRIES default, and the miss-counter width constant.
- One sub-module, p405s_itlb_victim_ptr: the round-robin pointer plus one-hot decode.

Test Plan:
- Reset mid-WAIT, then utlbAck=1 arrives -> entryValid=0, state IDLE, no writeShadow pulse.
- msrIrL2=1, all entries invalid, isReq with utlbAck/utlbHit=1 after 3 cycles -> writeShadow=4'b0001, RETRY compare hits, isStall high for 7 cycles.
- Five consecutive misses with UTLB hit -> writeShadow sequence 0001, 0010, 0100, 1000, 0001 (wrap).
- UTLB miss (utlbAck=1, utlbHit=0) -> isMissExc single pulse, no writeShadow, entryValid unchanged.
- isFlush asserted in WAIT -> entryValid=0, no fill, DRAIN until utlbAck, then IDLE.
- With the macro defined, 3 misses -> missCnt=3; force 0xFFFF then one more miss -> stays 0xFFFF.
